img_op_sequencer: RTL and testbench

IMG_OP_SEQUENCER -- requirements
Module: img_op_sequencer

---
 rtl/img_op_sequencer.sv | 132 +++++++++++++
 tb/tb_img_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_op_sequencer.sv
// Job sequencer that streams pixels through an external combinational pixel processor.
// Optional zero/full-scale output counter (port sat_cnt) enabled by defining IMG_SEQ_SATCNT_EN.
module img_op_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_value,
  input  logic [7:0]       cmd_thr,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pix,
  output logic             out_last,
  output logic [1:0]       proc_s,
  output logic [7:0]       proc_value,
  output logic [7:0]       proc_thr,
  output logic [7:0]       proc_ip,
  input  logic [7:0]       proc_op,
  input  logic             abort,
  output logic             busy,
  output logic             done
`ifdef IMG_SEQ_SATCNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for a job command
  // RUN   | accepting source pixels
  // FLUSH | last pixel taken, draining the result register
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic             cmd_fire, in_fire, out_fire, kill, last_hit;

  assign proc_ip  = in_pix;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign kill     = abort && ((state == RUN) || (state == FLUSH));
  assign last_hit = (cnt_q == (len_q - CNT_W'(1)));

  // Handshake outputs are forced low while reset is applied.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      done = (state == DONE);
      case (state)
        IDLE: begin
          cmd_ready = !abort;
          if (cmd_valid && !abort)
            state_nxt = (cmd_len == '0) ? DONE : RUN;
        end
        RUN: begin
          in_ready = !out_valid || out_ready;
          if (abort)
            state_nxt = IDLE;
          else if (in_valid && in_ready && last_hit)
            state_nxt = FLUSH;
        end
        FLUSH: begin
          if (abort)
            state_nxt = IDLE;
          else if (out_valid && out_ready && out_last)
            state_nxt = DONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      proc_s     <= '0;
      proc_value <= '0;
      proc_thr   <= '0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        proc_s     <= cmd_mode;
        proc_value <= cmd_value;
        proc_thr   <= cmd_thr;
        len_q      <= cmd_len;
        cnt_q      <= '0;
      end
      if (kill) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (in_fire) begin
        out_pix   <= proc_op;
        out_valid <= 1'b1;
        out_last  <= last_hit;
        cnt_q     <= cnt_q + CNT_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef IMG_SEQ_SATCNT_EN
  always_ff @(posedge clk) begin
    if (rst || cmd_fire)
      sat_cnt <= '0;
    else if (out_fire && ((out_pix == 8'h00) || (out_pix == 8'hFF)) && (sat_cnt != '1))
      sat_cnt <= sat_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_img_op_sequencer.sv
// Self-checking bench for img_op_sequencer: directed job scenarios plus randomized jobs
// scored against a stream-level reference model. Build with IMG_SEQ_SATCNT_EN to cover sat_cnt.
module tb_img_op_sequencer;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, in_valid, in_ready, out_valid, out_ready, out_last;
  logic abort, busy, done;
  logic [1:0] cmd_mode, proc_s;
  logic [7:0] cmd_value, cmd_thr, in_pix, out_pix, proc_value, proc_thr, proc_ip, proc_op;
  logic [CNT_W-1:0] cmd_len;
`ifdef IMG_SEQ_SATCNT_EN
  logic [CNT_W-1:0] sat_cnt;
`endif

  img_op_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_value(cmd_value), .cmd_thr(cmd_thr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_last(out_last),
    .proc_s(proc_s), .proc_value(proc_value), .proc_thr(proc_thr), .proc_ip(proc_ip),
    .proc_op(proc_op), .abort(abort), .busy(busy), .done(done)
`ifdef IMG_SEQ_SATCNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pixel arithmetic expressed directly from the operation definitions.
  function automatic logic [7:0] pix_op(input logic [1:0] m, input logic [7:0] v,
                                        input logic [7:0] t, input logic [7:0] ip);
    int r;
    case (m)
      2'd0:    r = (int'(ip) + int'(v) > 255) ? 255 : int'(ip) + int'(v);
      2'd1:    r = (int'(ip) - int'(v) < 0) ? 0 : int'(ip) - int'(v);
      2'd2:    r = (ip > t) ? 255 : 0;
      default: r = 255 - int'(ip);
    endcase
    return r[7:0];
  endfunction

  always_comb proc_op = pix_op(proc_s, proc_value, proc_thr, proc_ip);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state, updated from handshakes seen just after each falling edge.
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_out_cyc = 0, cmd_cyc = 0;
  int acc_cnt = 0, out_cnt = 0, sat_exp = 0, job_len = 0;
  logic [1:0] job_mode;
  logic [7:0] job_val, job_thr;
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] pix_src[$];
  bit seen_in_ready, seen_out_valid, prev_stall;
  logic [7:0] prev_pix;
  logic prev_last;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("hold_pix", out_pix, prev_pix);
        chk("hold_last", out_last, prev_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pix;
      prev_last  = out_last;
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (cmd_valid && cmd_ready) begin
        job_mode = cmd_mode; job_val = cmd_value; job_thr = cmd_thr; job_len = int'(cmd_len);
        acc_cnt = 0; out_cnt = 0; sat_exp = 0; cmd_cyc = cyc;
        exp_q.delete(); out_log.delete();
        seen_in_ready = 1'b0; seen_out_valid = 1'b0;
      end else begin
        if (in_ready) seen_in_ready = 1'b1;
        if (out_valid) seen_out_valid = 1'b1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("out_spurious", 1, 0);
          end else begin
            chk("out_pix", out_pix, exp_q.pop_front());
            chk("out_last", out_last, out_cnt == job_len - 1);
            chk("proc_s_hold", proc_s, job_mode);
          end
          out_log.push_back(out_pix);
          out_cnt++;
          if (out_pix == 8'd0 || out_pix == 8'd255) sat_exp++;
          last_out_cyc = cyc;
        end
        if (in_valid && in_ready) begin
          chk("in_overrun", acc_cnt < job_len, 1);
          chk("proc_ip", proc_ip, in_pix);
          exp_q.push_back(pix_op(job_mode, job_val, job_thr, in_pix));
          acc_cnt++;
        end
        if (abort && busy) begin
          exp_q.delete();
          prev_stall = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  // Issues one job and streams pix_src through it; returns on done, abort or timeout.
  task automatic do_job(input logic [1:0] m, input logic [7:0] v, input logic [7:0] t,
                        input int len, input int in_pct, input int out_pct,
                        input bit stall3, input int abort_after);
    int d0, sent, stall_left, wait_n;
    bit stall_started, abort_done, finished;
    d0 = done_cnt; sent = 0; stall_left = 0; stall_started = 0; abort_done = 0; finished = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_value = v; cmd_thr = t; cmd_len = CNT_W'(len);
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
    wait_n = 0;
    forever begin
      #2;
      if (cmd_ready) break;
      wait_n++;
      if (wait_n > 20) begin chk("cmd_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_cnt != d0 || abort_done) begin finished = 1; break; end
      in_valid = (pix_src.size() > 0) && ($urandom_range(99) < in_pct);
      in_pix = in_valid ? pix_src[0] : 8'($urandom);
      if (stall3) begin
        if (!stall_started && out_valid) begin stall_started = 1; stall_left = 3; end
        if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(99) < out_pct);
      end
      abort = (abort_after >= 0) && (sent == abort_after);
      #2;
      if (in_valid && in_ready) begin void'(pix_src.pop_front()); sent++; end
      if (abort) abort_done = 1;
      @(negedge clk);
      abort = 1'b0;
    end
    if (!finished) chk("job_timeout", 0, 1);
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
    if (abort_after < 0) begin
      #2;
      chk("out_count", out_cnt, len);
      chk("done_pulses", done_cnt - d0, 1);
      chk("idle_after_done", {busy, done}, 0);
`ifdef IMG_SEQ_SATCNT_EN
      chk("sat_cnt", sat_cnt, sat_exp);
`endif
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_value = '0; cmd_thr = '0; cmd_len = '0;
    in_valid = 1'b0; in_pix = '0; out_ready = 1'b1; abort = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outs", {in_ready, out_valid, out_last, busy, done}, 0);
    chk("rst_regs", {out_pix, proc_s, proc_value, proc_thr}, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_in_ready", in_ready, 0);
    abort = 1'b1;
    #1;
    chk("abort_blocks_cmd", cmd_ready, 0);
    abort = 1'b0;

    // add-saturate, free-flowing
    pix_src = '{8'd10, 8'd200, 8'd155};
    do_job(2'd0, 8'd100, 8'd0, 3, 100, 100, 0, -1);
    chk("add_o0", out_log[0], 110);
    chk("add_o1", out_log[1], 255);
    chk("add_o2", out_log[2], 255);
    chk("add_done_lat", done_cyc - last_out_cyc, 1);

    // subtract-clamp with a 3-cycle output stall
    pix_src = '{8'd30, 8'd80};
    do_job(2'd1, 8'd50, 8'd0, 2, 100, 100, 1, -1);
    chk("sub_o0", out_log[0], 0);
    chk("sub_o1", out_log[1], 30);

    // threshold
    pix_src = '{8'd128, 8'd129, 8'd0, 8'd255};
    do_job(2'd2, 8'd0, 8'd128, 4, 100, 100, 0, -1);
    chk("thr_o0", out_log[0], 0);
    chk("thr_o1", out_log[1], 255);
    chk("thr_o2", out_log[2], 0);
    chk("thr_o3", out_log[3], 255);
`ifdef IMG_SEQ_SATCNT_EN
    chk("thr_sat_cnt", sat_cnt, 4);
`endif

    // zero-length job
    pix_src = '{8'd7};
    do_job(2'd0, 8'd1, 8'd0, 0, 100, 100, 0, -1);
    chk("len0_in_ready", seen_in_ready, 0);
    chk("len0_out_valid", seen_out_valid, 0);
    chk("len0_done_lat", (done_cyc - cmd_cyc >= 1) && (done_cyc - cmd_cyc <= 2), 1);
    pix_src.delete();

    // abort mid-job, then a clean one-pixel job
    for (int i = 0; i < 5; i++) pix_src.push_back(8'($urandom));
    d0 = done_cnt;
    do_job(2'd3, 8'd0, 8'd0, 5, 100, 100, 0, 2);
    #2;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    pix_src = '{8'd0};
    do_job(2'd3, 8'd0, 8'd0, 1, 100, 100, 0, -1);
    chk("inv_o0", out_log[0], 255);

    // reset while FLUSH holds a result
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_value = 8'd0; cmd_thr = 8'd0; cmd_len = CNT_W'(1);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_pix = 8'd9; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("flush_out_valid", out_valid, 1);
    chk("flush_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #2;
    chk("rstflush_outs", {out_valid, busy, done}, 0);
    chk("rstflush_proc_s", proc_s, 0);

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      int len;
      len = $urandom_range(8);
      pix_src.delete();
      for (int i = 0; i < len; i++) pix_src.push_back(8'($urandom));
      do_job(2'($urandom), 8'($urandom), 8'($urandom), len,
             $urandom_range(100, 40), $urandom_range(100, 30), 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
